// File: rtl/seq_pkg.sv
// Shared types and helpers for the pipeline-stage sequencer: the control
// operation encoding, cause-code builders and a lowest-index priority encoder.
package seq_pkg;

   typedef enum logic [1:0] {
      OP_TRAP   = 2'b00,
      OP_IRQ    = 2'b01,
      OP_NORMAL = 2'b11
   } op_e;

   // Dwell counter width; covers the legal MIN_DWELL range of 1..15.
   localparam int unsigned DWELL_W = 4;

   // Widest request vector the priority-encoder function accepts.
   localparam int unsigned ENC_MAX = 32;

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic int unsigned lowest_set(input logic [ENC_MAX-1:0] vec);
      int unsigned idx;
      idx = 0;
      for (int i = ENC_MAX - 1; i >= 0; i--) begin
         if (vec[i]) idx = unsigned'(i);
      end
      return idx;
   endfunction

   // Fault cause: MSB clear, then the winning fault index, then the store flag.
   function automatic int unsigned fault_cause(input int unsigned idx, input logic is_store);
      return (idx << 1) | 32'(is_store);
   endfunction

   // Interrupt cause: MSB of the cause field set, interrupt index in the low bits.
   function automatic int unsigned irq_cause(input int unsigned cause_w, input int unsigned idx);
      return (32'd1 << (cause_w - 1)) | idx;
   endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag. Supports N up to
// ENC_MAX request lines.
module prio_enc
   import seq_pkg::*;
#(
   parameter  int unsigned N     = 4,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   assign valid_o = |req_i;
   assign idx_o   = IDX_W'(lowest_set(ENC_MAX'(req_i)));

endmodule

// File: rtl/stage_sequencer.sv
// One-hot pipeline-stage sequencer: steps through NUM_STAGES stages with a
// minimum dwell per stage, captures qualified faults as traps, arbitrates
// interrupts at instruction boundaries and counts retired instructions.
module stage_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 7,
   parameter int unsigned NUM_FAULTS = 4,
   parameter int unsigned NUM_IRQS   = 2,
   parameter logic [NUM_FAULTS*NUM_STAGES-1:0] FAULT_STAGE_MASK =
      {NUM_FAULTS{{{(NUM_STAGES-1){1'b1}}, 1'b0}}},
   parameter int unsigned MIN_DWELL  = 1,
   parameter int unsigned CAUSE_W    = 4,
   parameter int unsigned RETIRE_W   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_STAGES-1:0] stage_done,
   input  logic [NUM_FAULTS-1:0] fault_req,
   input  logic                  fault_is_store,
   input  logic [NUM_IRQS-1:0]   irq_pending,
   input  logic                  irq_enable,
   input  logic                  hold,
   output logic [NUM_STAGES-1:0] stage_active,
   output logic [1:0]            control_op,
   output logic [CAUSE_W-1:0]    cause,
   output logic                  trap_pulse,
   output logic                  retire_pulse,
   output logic [RETIRE_W-1:0]   retire_count
);

   localparam int unsigned F_IDX_W = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1;
   localparam int unsigned I_IDX_W = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;
   localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MIN_DWELL);

   logic [NUM_STAGES-1:0] stage_q, stage_d;
   logic [DWELL_W-1:0]    dwell_q, dwell_d;
   op_e                   op_q, op_d;
   logic [CAUSE_W-1:0]    cause_q, cause_d;
   logic                  trap_q, trap_d;
   logic                  retire_q, retire_d;
   logic [RETIRE_W-1:0]   count_q, count_d;
   logic                  arb_q, arb_d;

   logic [NUM_FAULTS-1:0] f_hit;
   logic                  fault_vld;
   logic [F_IDX_W-1:0]    fault_idx;
   logic                  irq_vld;
   logic [I_IDX_W-1:0]    irq_idx;
   logic                  done;

   // Qualify each fault request against the mask bits of the active stage.
   always_comb begin
      f_hit = '0;
      for (int f = 0; f < NUM_FAULTS; f++) begin
         f_hit[f] = fault_req[f] & (|(FAULT_STAGE_MASK[f*NUM_STAGES +: NUM_STAGES] & stage_q));
      end
   end

   prio_enc #(.N(NUM_FAULTS)) u_fault_enc (
      .req_i   (f_hit),
      .valid_o (fault_vld),
      .idx_o   (fault_idx)
   );

   // Masking by the global enable here makes irq_vld the full "take IRQ" term.
   prio_enc #(.N(NUM_IRQS)) u_irq_enc (
      .req_i   (irq_pending & {NUM_IRQS{irq_enable}}),
      .valid_o (irq_vld),
      .idx_o   (irq_idx)
   );

   assign done = (|(stage_q & stage_done)) && (dwell_q == DWELL_MAX) && !hold;

   // Next-state: dwell, arbitration load, fault capture and stage advance.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a variable unassigned and infer a latch; pulses default to 0.
      stage_d  = stage_q;
      dwell_d  = dwell_q;
      op_d     = op_q;
      cause_d  = cause_q;
      trap_d   = 1'b0;
      retire_d = 1'b0;
      count_d  = count_q;
      arb_d    = arb_q;

      if (!hold) begin
         if (dwell_q != DWELL_MAX) dwell_d = dwell_q + DWELL_W'(1);

         // Interrupt arbitration happens once, at the start of an instruction.
         if (arb_q) begin
            if (irq_vld) begin
               op_d    = OP_IRQ;
               cause_d = CAUSE_W'(irq_cause(CAUSE_W, 32'(irq_idx)));
            end else begin
               op_d    = OP_NORMAL;
            end
            arb_d = 1'b0;
         end

         if (done) begin
            dwell_d = '0;
            if (fault_vld) begin
               // Fault capture overrides any arbitration in the same cycle and
               // cancels the pending one so the TRAP cannot be overwritten.
               stage_d = NUM_STAGES'(1);
               op_d    = OP_TRAP;
               cause_d = CAUSE_W'(fault_cause(32'(fault_idx), fault_is_store));
               trap_d  = 1'b1;
               arb_d   = 1'b0;
            end else begin
               stage_d = {stage_q[NUM_STAGES-2:0], stage_q[NUM_STAGES-1]};
               if (stage_q[NUM_STAGES-1]) begin
                  retire_d = 1'b1;
                  count_d  = count_q + RETIRE_W'(1);
                  arb_d    = 1'b1;
               end
            end
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      if (reset) begin
         stage_q  <= NUM_STAGES'(1);
         dwell_q  <= '0;
         op_q     <= OP_NORMAL;
         cause_q  <= '0;
         trap_q   <= 1'b0;
         retire_q <= 1'b0;
         count_q  <= '0;
         arb_q    <= 1'b1;
      end else begin
         stage_q  <= stage_d;
         dwell_q  <= dwell_d;
         op_q     <= op_d;
         cause_q  <= cause_d;
         trap_q   <= trap_d;
         retire_q <= retire_d;
         count_q  <= count_d;
         arb_q    <= arb_d;
      end
   end

   assign stage_active = stage_q;
   assign control_op   = op_q;
   assign cause        = cause_q;
   assign trap_pulse   = trap_q;
   assign retire_pulse = retire_q;
   assign retire_count = count_q;

   a_stage_onehot : assert property (@(posedge clk) disable iff (reset) $onehot(stage_q));

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer. A behavioural model predicts each
// cycle's outputs from the inputs about to be sampled; predictions are queued
// and compared after the edge. Scenario tasks add direct checks of the
// values the scenarios are built around.
module tb_stage_sequencer;
   import seq_pkg::*;

   localparam int NS = 7;
   localparam int NF = 4;
   localparam int NI = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [NS-1:0] stage_done;
   logic [NF-1:0] fault_req;
   logic          fault_is_store;
   logic [NI-1:0] irq_pending;
   logic          irq_enable;
   logic          hold;

   logic [NS-1:0] stage_active, stage_active_w4;
   logic [1:0]    control_op, control_op_w4;
   logic [3:0]    cause, cause_w4;
   logic          trap_pulse, trap_pulse_w4;
   logic          retire_pulse, retire_pulse_w4;
   logic [31:0]   retire_count;
   logic [3:0]    retire_count_w4;

   always #5 clk = ~clk;

   stage_sequencer dut (
      .clk(clk), .reset(reset), .stage_done(stage_done), .fault_req(fault_req),
      .fault_is_store(fault_is_store), .irq_pending(irq_pending), .irq_enable(irq_enable),
      .hold(hold), .stage_active(stage_active), .control_op(control_op), .cause(cause),
      .trap_pulse(trap_pulse), .retire_pulse(retire_pulse), .retire_count(retire_count)
   );

   stage_sequencer #(.RETIRE_W(4)) dut_w4 (
      .clk(clk), .reset(reset), .stage_done(stage_done), .fault_req(fault_req),
      .fault_is_store(fault_is_store), .irq_pending(irq_pending), .irq_enable(irq_enable),
      .hold(hold), .stage_active(stage_active_w4), .control_op(control_op_w4), .cause(cause_w4),
      .trap_pulse(trap_pulse_w4), .retire_pulse(retire_pulse_w4), .retire_count(retire_count_w4)
   );

   typedef struct packed {
      logic [NS-1:0] stage;
      logic [1:0]    op;
      logic [3:0]    cause;
      logic          trap;
      logic          retire;
      logic [31:0]   count;
   } snap_t;

   snap_t exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   // Model state (MIN_DWELL = 1: a stage completes on its second cycle).
   int          m_stage = 0;
   bit          m_met   = 1'b0;
   logic [1:0]  m_op    = OP_NORMAL;
   logic [3:0]  m_cause = '0;
   logic [31:0] m_count = '0;
   bit          m_arb   = 1'b1;

   function automatic int lowest_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic string fmt(input snap_t s);
      return $sformatf("stage=%b op=%b cause=%b trap=%b ret=%b cnt=%0d",
                       s.stage, s.op, s.cause, s.trap, s.retire, s.count);
   endfunction

   function automatic snap_t observe();
      snap_t s;
      s = '{stage_active, control_op, cause, trap_pulse, retire_pulse, retire_count};
      return s;
   endfunction

   function automatic snap_t observe_w4();
      snap_t s;
      s = '{stage_active_w4, control_op_w4, cause_w4, trap_pulse_w4, retire_pulse_w4,
            {28'b0, retire_count_w4}};
      return s;
   endfunction

   // Predict the outputs after the coming edge from the inputs now applied.
   task automatic predict();
      snap_t         s;
      bit            trap = 1'b0;
      bit            ret  = 1'b0;
      logic [NF-1:0] hits;
      if (reset) begin
         m_stage = 0; m_met = 1'b0; m_op = OP_NORMAL; m_cause = '0; m_count = '0; m_arb = 1'b1;
      end else if (!hold) begin
         if (m_arb) begin
            if (irq_enable && irq_pending != '0) begin
               m_op    = OP_IRQ;
               m_cause = 4'b1000 | 4'(lowest_idx({2'b00, irq_pending}));
            end else begin
               m_op    = OP_NORMAL;
            end
            m_arb = 1'b0;
         end
         if (m_met && stage_done[m_stage]) begin
            hits = (m_stage == 0) ? '0 : fault_req;
            if (hits != '0) begin
               m_op    = OP_TRAP;
               m_cause = {1'b0, 2'(lowest_idx(hits)), fault_is_store};
               trap    = 1'b1;
               m_arb   = 1'b0;
               m_stage = 0;
            end else begin
               if (m_stage == NS - 1) begin
                  ret     = 1'b1;
                  m_count = m_count + 32'd1;
                  m_arb   = 1'b1;
               end
               m_stage = (m_stage + 1) % NS;
            end
            m_met = 1'b0;
         end else begin
            m_met = 1'b1;
         end
      end
      s        = '0;
      s.stage[m_stage] = 1'b1;
      s.op     = m_op;
      s.cause  = m_cause;
      s.trap   = trap;
      s.retire = ret;
      s.count  = m_count;
      exp_q.push_back(s);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      snap_t got, want;
      reset = 1'b1; stage_done = '0; fault_req = '0; fault_is_store = 1'b0;
      irq_pending = '0; irq_enable = 1'b0; hold = 1'b0;
      for (int i = 0; i < 2; i++) begin
         predict(); tick();
         want = exp_q.pop_front(); got = observe(); n_cmp++;
         if (got !== want) begin
            n_bad++; $display("FAIL reset[%0d]: got %s want %s", i, fmt(got), fmt(want));
         end
      end
      n_cmp++;
      if ({stage_active, control_op, cause, trap_pulse, retire_pulse, retire_count, retire_count_w4}
          !== {7'b0000001, 2'b11, 4'b0000, 1'b0, 1'b0, 32'd0, 4'd0}) begin
         n_bad++;
         $display("FAIL reset_values: got stage=%b op=%b cause=%b trap=%b ret=%b cnt=%0d cnt4=%0d want 0000001/11/0000/0/0/0/0",
                  stage_active, control_op, cause, trap_pulse, retire_pulse, retire_count, retire_count_w4);
      end
      reset = 1'b0;
   endtask

   task automatic test_normal_run();
      snap_t got, want;
      int    pulses = 0;
      stage_done = '1;
      for (int i = 0; i < 28; i++) begin
         predict(); tick();
         want = exp_q.pop_front(); got = observe(); n_cmp++;
         if (got !== want) begin
            n_bad++; $display("FAIL normal_run[%0d]: got %s want %s", i, fmt(got), fmt(want));
         end
         pulses += int'(retire_pulse);
         if (i == 13) begin
            n_cmp++;
            if ({stage_active, retire_pulse, retire_count, control_op} !== {7'b0000001, 1'b1, 32'd1, 2'b11}) begin
               n_bad++;
               $display("FAIL first_wrap: got stage=%b ret=%b cnt=%0d op=%b want 0000001/1/1/11",
                        stage_active, retire_pulse, retire_count, control_op);
            end
         end
      end
      n_cmp++;
      if (pulses != 2) begin
         n_bad++; $display("FAIL retire_rate: got %0d pulses in 28 cycles want 2", pulses);
      end
   endtask

   task automatic test_fault_capture();
      snap_t       got, want;
      bit          fired = 1'b0;
      logic [31:0] cnt_before;
      for (int i = 0; i < 40 && !fired; i++) begin
         // Fault held through both cycles of stage 5; only the completion edge samples it.
         fault_req      = (m_stage == 5) ? 4'b0110 : 4'b0000;
         fault_is_store = (m_stage == 5);
         fired          = (m_stage == 5) && m_met;
         cnt_before     = m_count;
         predict(); tick();
         want = exp_q.pop_front(); got = observe(); n_cmp++;
         if (got !== want) begin
            n_bad++; $display("FAIL fault_capture[%0d]: got %s want %s", i, fmt(got), fmt(want));
         end
         if (fired) begin
            n_cmp++;
            if ({stage_active, control_op, cause, trap_pulse, retire_pulse} !== {7'b0000001, 2'b00, 4'b0011, 1'b1, 1'b0}) begin
               n_bad++;
               $display("FAIL fault_trap: got stage=%b op=%b cause=%b trap=%b ret=%b want 0000001/00/0011/1/0",
                        stage_active, control_op, cause, trap_pulse, retire_pulse);
            end
            n_cmp++;
            if (retire_count !== cnt_before) begin
               n_bad++; $display("FAIL fault_no_retire: got cnt=%0d want %0d", retire_count, cnt_before);
            end
         end
      end
      if (!fired) begin
         n_cmp++; n_bad++; $display("FAIL fault_capture: stage 5 completion not reached");
      end
      fault_req = '0; fault_is_store = 1'b0;
   endtask

   task automatic test_stage0_fault();
      snap_t got, want;
      bit    left = 1'b0;
      fault_req = 4'b0001; fault_is_store = 1'b1;
      for (int i = 0; i < 4 && !left; i++) begin
         predict(); tick();
         want = exp_q.pop_front(); got = observe(); n_cmp++;
         if (got !== want) begin
            n_bad++; $display("FAIL stage0_fault[%0d]: got %s want %s", i, fmt(got), fmt(want));
         end
         left = (want.stage != 7'b0000001);
      end
      n_cmp++;
      if ({stage_active, trap_pulse, control_op, cause} !== {7'b0000010, 1'b0, 2'b00, 4'b0011}) begin
         n_bad++;
         $display("FAIL stage0_ignored: got stage=%b trap=%b op=%b cause=%b want 0000010/0/00/0011",
                  stage_active, trap_pulse, control_op, cause);
      end
      fault_req = '0; fault_is_store = 1'b0;
   endtask

   task automatic test_irq();
      snap_t got, want;
      bit    armed, loaded;
      irq_pending = 2'b10;
      for (int p = 0; p < 2; p++) begin
         irq_enable = (p == 0);
         loaded = 1'b0;
         for (int i = 0; i < 40 && !loaded; i++) begin
            armed = m_arb;
            predict(); tick();
            want = exp_q.pop_front(); got = observe(); n_cmp++;
            if (got !== want) begin
               n_bad++; $display("FAIL irq[%0d.%0d]: got %s want %s", p, i, fmt(got), fmt(want));
            end
            if (armed) begin
               loaded = 1'b1;
               n_cmp++;
               if ({control_op, cause} !== ((p == 0) ? {2'b01, 4'b1001} : {2'b11, 4'b1001})) begin
                  n_bad++;
                  $display("FAIL irq_load[%0d]: got op=%b cause=%b want op=%s cause=1001",
                           p, control_op, cause, (p == 0) ? "01" : "11");
               end
            end
         end
         if (!loaded) begin
            n_cmp++; n_bad++; $display("FAIL irq[%0d]: arbitration point not reached", p);
         end
      end
      irq_pending = '0; irq_enable = 1'b0;
   endtask

   task automatic test_hold();
      snap_t got, want;
      int    held = 0;
      bit    fin  = 1'b0;
      for (int i = 0; i < 60 && !fin; i++) begin
         hold = (m_stage == 3 && m_met && held < 5);
         predict(); tick();
         want = exp_q.pop_front(); got = observe(); n_cmp++;
         if (got !== want) begin
            n_bad++; $display("FAIL hold[%0d]: got %s want %s", i, fmt(got), fmt(want));
         end
         if (hold) begin
            held++;
            n_cmp++;
            if ({stage_active, trap_pulse, retire_pulse} !== {7'b0001000, 1'b0, 1'b0}) begin
               n_bad++; $display("FAIL hold_frozen[%0d]: got stage=%b trap=%b ret=%b want 0001000/0/0",
                                 held, stage_active, trap_pulse, retire_pulse);
            end
         end else if (held == 5) begin
            fin = 1'b1;
            n_cmp++;
            if (stage_active !== 7'b0010000) begin
               n_bad++; $display("FAIL hold_release: got stage=%b want 0010000", stage_active);
            end
         end
      end
      if (!fin) begin
         n_cmp++; n_bad++; $display("FAIL hold: hold window in stage 3 not completed");
      end
      hold = 1'b0;
   endtask

   task automatic test_reset_mid_stage();
      snap_t got, want;
      bit    found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         found = (m_stage == 4);
         reset = found;
         predict(); tick();
         want = exp_q.pop_front(); got = observe(); n_cmp++;
         if (got !== want) begin
            n_bad++; $display("FAIL reset_mid[%0d]: got %s want %s", i, fmt(got), fmt(want));
         end
      end
      if (!found) begin
         n_cmp++; n_bad++; $display("FAIL reset_mid: stage 4 not reached");
      end
      n_cmp++;
      if ({stage_active, control_op, cause, trap_pulse, retire_pulse, retire_count}
          !== {7'b0000001, 2'b11, 4'b0000, 1'b0, 1'b0, 32'd0}) begin
         n_bad++;
         $display("FAIL reset_mid_values: got stage=%b op=%b cause=%b trap=%b ret=%b cnt=%0d want 0000001/11/0000/0/0/0",
                  stage_active, control_op, cause, trap_pulse, retire_pulse, retire_count);
      end
      reset = 1'b0;
   endtask

   task automatic test_retire_wrap();
      snap_t got, want, want4;
      int    retires = 0;
      for (int i = 0; i < 300 && retires < 16; i++) begin
         predict(); tick();
         want = exp_q.pop_front(); got = observe(); n_cmp++;
         if (got !== want) begin
            n_bad++; $display("FAIL retire_wrap[%0d]: got %s want %s", i, fmt(got), fmt(want));
         end
         want4 = want;
         want4.count = {28'b0, want.count[3:0]};
         got = observe_w4(); n_cmp++;
         if (got !== want4) begin
            n_bad++; $display("FAIL retire_wrap_w4[%0d]: got %s want %s", i, fmt(got), fmt(want4));
         end
         retires += int'(want.retire);
      end
      n_cmp++;
      if (retires != 16 || retire_count_w4 !== 4'd0 || retire_count !== 32'd16) begin
         n_bad++;
         $display("FAIL count_wrap: got retires=%0d cnt4=%0d cnt=%0d want 16/0/16",
                  retires, retire_count_w4, retire_count);
      end
   endtask

   initial begin
      test_reset();
      test_normal_run();
      test_fault_capture();
      test_stage0_fault();
      test_irq();
      test_hold();
      test_reset_mid_stage();
      test_retire_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Parametrised one-hot pipeline-stage sequencer for the multi-cycle core. It steps through NUM_STAGES stages and enforces a minimum dwell time per stage. It arbitrates any number of per-stage-qualified fault sources and prioritised interrupt lines into a control operation plus a cause code, and counts retired instructions. It sits between the stage datapaths (which raise stage_done and fault requests) and the control/trap stage (which consumes control_op and cause).

Parameters:
NUM_STAGES, 7, number of stages; stage 0 is always the control stage.
NUM_FAULTS, 4, number of fault request lines; index 0 has the highest priority.
NUM_IRQS, 2, number of interrupt lines; index 0 has the highest priority.
FAULT_STAGE_MASK, {NUM_FAULTS*NUM_STAGES}, bit [f*NUM_STAGES+s] = 1 means fault f is honoured in stage s. Default is all ones except every stage-0 bit.
MIN_DWELL, 1, cycles a stage must be active before stage_done is honoured. Legal range is 1..15.
CAUSE_W, 4, cause width. Must satisfy CAUSE_W >= 1 + max($clog2(NUM_FAULTS)+1, $clog2(NUM_IRQS)).
RETIRE_W, 32, retire counter width.

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
stage_done  in  NUM_STAGES  per-stage done flags
fault_req  in  NUM_FAULTS  fault requests, sampled only at stage completion
fault_is_store  in  1  qualifies the fault as a store access
irq_pending  in  NUM_IRQS  level interrupt requests
irq_enable  in  1  global interrupt enable
hold  in  1  freezes all sequencing
stage_active  out  NUM_STAGES  one-hot current stage
control_op  out  2  2'b00 TRAP, 2'b01 IRQ, 2'b11 NORMAL (2'b10 never driven)
cause  out  CAUSE_W  trap/irq cause code
trap_pulse  out  1  one-cycle pulse on fault capture
retire_pulse  out  1  one-cycle pulse on fault-free completion of the last stage
retire_count  out  RETIRE_W  retired-instruction count

Behaviour:
- Reset (synchronous, takes priority over everything):
  - stage_active=1<<0, control_op=NORMAL, cause=0.
  - trap_pulse=0, retire_pulse=0, retire_count=0, dwell=0.
  - The internal "arbitrate" flag is set to 1.
- Dwell counter: cleared on every stage change; increments each non-hold cycle and saturates at MIN_DWELL.
- Completion: done = |(stage_active & stage_done) & (dwell==MIN_DWELL) & ~hold.
- hold=1 freezes dwell, stage_active, control_op, cause and counters; pulses are forced to 0.
- Fault qualify: f_hit[f] = fault_req[f] & FAULT_STAGE_MASK[f*NUM_STAGES + current stage index]. Stage 0 never faults with the default mask.
- On done with |f_hit (winner w = lowest set index), next cycle:
  - stage_active=1<<0, control_op=TRAP, cause={1'b0, w, fault_is_store}, zero-extended.
  - trap_pulse=1; arbitrate flag cleared.
- On done without a fault hit:
  - stage_active rotates left by one; from stage NUM_STAGES-1 it wraps to stage 0.
  - From the last stage, retire_pulse=1 and retire_count+1, wrapping modulo 2^RETIRE_W.
  - On wrap to stage 0 the arbitrate flag is set.
- Arbitration: in the first non-hold cycle with arbitrate=1, control_op and cause are loaded, then arbitrate is cleared.
  - If irq_enable & |irq_pending: control_op=IRQ, cause={1'b1, lowest pending index}, zero-extended.
  - Otherwise control_op=NORMAL and cause is unchanged.
- A TRAP loaded on fault is never overwritten by interrupt arbitration. Fault beats IRQ in the same cycle.
- control_op and cause are stable from load until the next load.
- Minimum time in any stage is MIN_DWELL+1 cycles.
- fault_req and irq_pending are ignored outside the sampling points above.
- Reset mid-stage abandons the instruction: no retire, no trap_pulse.
- stage_active is always exactly one-hot. This is a required assertion.

Decomposition:
- Package seq_pkg holds:
  - the control_op enum (OP_TRAP=2'b00, OP_IRQ=2'b01, OP_NORMAL=2'b11);
  - the cause-field helpers and the priority-encoder function.
- Sub-module prio_enc #(N) covers lowest-index-wins plus a valid bit. Instantiate it twice, for faults and irqs.

Test Plan:
1. Reset, then stage_done=all ones with no faults/irqs, MIN_DWELL=1 → each stage active exactly 2 cycles, stage 6→0 wrap, retire_pulse once per 14 cycles, retire_count=1 after the first wrap, control_op=NORMAL.
2. In stage 5, fault_req=4'b0110 and fault_is_store=1 at completion → next cycle stage_active=7'b0000001, control_op=TRAP, cause=4'b0011, trap_pulse=1, retire_count unchanged.
3. fault_req[0]=1 during stage 0 (default mask) → ignored; normal advance to stage 1.
4. irq_pending=2'b10, irq_enable=1 at wrap to stage 0 → control_op=IRQ, cause=4'b1001. Same with irq_enable=0 → NORMAL.
5. hold=1 for 5 cycles mid-stage 3 with stage_done high → stage_active unchanged, no pulses; advance 1 cycle after hold drops (dwell already met).
6. Assert reset in stage 4 → next cycle stage 0, all outputs at reset values. RETIRE_W=4 run of 16 instructions → retire_count wraps to 0.
